// File: rtl/pwr_event_decoder_pkg.sv
// pwr_event_decoder_pkg: shared classifier states, event indices (priority order) and ms defaults
package pwr_event_decoder_pkg;
    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} press_state_e;
    localparam int CNT_W = 13;
    typedef logic [CNT_W-1:0] ms_cnt_t;
    // Lower index wins arbitration
    localparam int EV_FORCE_OFF      = 0;
    localparam int EV_PWR_ON_OFF     = 1;
    localparam int EV_NORMAL_REBOOT  = 2;
    localparam int EV_HOST_POWER_OFF = 3;
    localparam int EV_HOST_REBOOT    = 4;
    localparam int NUM_EV            = 5;
    typedef logic [NUM_EV-1:0] ev_vec_t;
    localparam int DEBOUNCE_MS_DEF  = 20;
    localparam int SHORT_MIN_MS_DEF = 50;
    localparam int LONG_MS_DEF      = 4000;
    localparam int HOST_MIN_MS_DEF  = 100;
    localparam int HOLDOFF_MS_DEF   = 200;
    function automatic ev_vec_t pick_first(ev_vec_t req);
        return req & (~req + ev_vec_t'(1));
    endfunction
endpackage

// File: rtl/pwr_event_decoder_if.sv
// pwr_event_decoder_if: tick, raw event inputs and active-low event strobes
interface pwr_event_decoder_if;
    logic int_1ms_en;
    logic pwr_btn;
    logic rst_btn;
    logic bmc_power_out;
    logic bmc_reset_out;
    logic host_reboot;
    logic post_complete;
    logic host_pwr_off;
    logic is_pwr_on_off;
    logic is_pwr_force_off;
    logic is_normal_reboot;
    logic is_host_reboot;
    logic is_host_power_off;
    modport master (
        output int_1ms_en, pwr_btn, rst_btn, bmc_power_out, bmc_reset_out,
               host_reboot, post_complete, host_pwr_off,
        input  is_pwr_on_off, is_pwr_force_off, is_normal_reboot, is_host_reboot, is_host_power_off
    );
    modport slave (
        input  int_1ms_en, pwr_btn, rst_btn, bmc_power_out, bmc_reset_out,
               host_reboot, post_complete, host_pwr_off,
        output is_pwr_on_off, is_pwr_force_off, is_normal_reboot, is_host_reboot, is_host_power_off
    );
endinterface

// File: rtl/pwr_event_decoder_press_classifier.sv
// press_classifier: debounces one press source and classifies each press by its duration
module press_classifier
    import pwr_event_decoder_pkg::*;
#(
    parameter int DEBOUNCE_MS  = DEBOUNCE_MS_DEF,
    parameter int SHORT_MIN_MS = SHORT_MIN_MS_DEF,
    parameter int LONG_MS      = LONG_MS_DEF,
    parameter bit LONG_EN      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic short_req,
    output logic long_req
);
    localparam ms_cnt_t DEB_LAST  = ms_cnt_t'(DEBOUNCE_MS - 1);
    localparam ms_cnt_t SHORT_MIN = ms_cnt_t'(SHORT_MIN_MS);
    localparam ms_cnt_t LONG      = ms_cnt_t'(LONG_MS);

    press_state_e state_q, state_d;
    ms_cnt_t deb_cnt_q, deb_cnt_d, dur_q, dur_d;
    logic lvl_q, lvl_d, accept;

    always_comb begin
        accept = tick && (raw != lvl_q) && (deb_cnt_q == DEB_LAST);
        lvl_d = accept ? raw : lvl_q;
        deb_cnt_d = (raw == lvl_q || accept) ? '0 : tick ? deb_cnt_q + ms_cnt_t'(1) : deb_cnt_q;
        dur_d = (state_q == PRESSED && tick && dur_q != '1) ? dur_q + ms_cnt_t'(1) : dur_q;
        state_d = state_q;
        short_req = 1'b0;
        long_req = 1'b0;
        case (state_q)
            IDLE: if (accept && raw) begin
                state_d = PRESSED;
                dur_d = '0;
            end
            PRESSED: if (accept && !raw) begin
                state_d = IDLE;
                short_req = dur_q >= SHORT_MIN && (!LONG_EN || dur_q < LONG);
            end else if (LONG_EN && tick && dur_d == LONG) begin
                state_d = LONG_HELD;
                long_req = 1'b1;
            end
            LONG_HELD: if (accept && !raw) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The level starts as pressed so a button held through reset needs a release before it counts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            deb_cnt_q <= '0;
            dur_q <= '0;
            lvl_q <= 1'b1;
        end else begin
            state_q <= state_d;
            deb_cnt_q <= deb_cnt_d;
            dur_q <= dur_d;
            lvl_q <= lvl_d;
        end
    end
endmodule

// File: rtl/pwr_event_decoder.sv
// pwr_event_decoder: synchronizes power/reset/host inputs and emits arbitrated one-clock active-low event strobes
module pwr_event_decoder
    import pwr_event_decoder_pkg::*;
#(
    parameter int DEBOUNCE_MS  = DEBOUNCE_MS_DEF,
    parameter int SHORT_MIN_MS = SHORT_MIN_MS_DEF,
    parameter int LONG_MS      = LONG_MS_DEF,
    parameter int HOST_MIN_MS  = HOST_MIN_MS_DEF,
    parameter int HOLDOFF_MS   = HOLDOFF_MS_DEF
) (
    input  logic clock,
    input  logic reset,
    pwr_event_decoder_if.slave bus
);
    // Order: pwr_btn, bmc_power_out, rst_btn, bmc_reset_out, host_reboot, post_complete
    localparam logic [5:0] SYNC_INIT = 6'b111100;
    localparam ms_cnt_t HOST_LAST = ms_cnt_t'(HOST_MIN_MS - 1);
    localparam ms_cnt_t HOLDOFF   = ms_cnt_t'(HOLDOFF_MS);

    logic [5:0] meta_q, meta_d, sync_q, sync_d;
    logic hr_prev_q, hr_prev_d, host_armed_q, host_armed_d;
    ms_cnt_t host_cnt_q, host_cnt_d, holdoff_q, holdoff_d;
    ev_vec_t strobe_q, strobe_d, req;
    logic pwr_src, rst_src, pc, host_fire, hold;
    logic pwr_short, pwr_long, rst_short, rst_long;

    press_classifier #(
        .DEBOUNCE_MS(DEBOUNCE_MS), .SHORT_MIN_MS(SHORT_MIN_MS), .LONG_MS(LONG_MS), .LONG_EN(1'b1)
    ) u_pwr (
        .clock(clock), .reset(reset), .tick(bus.int_1ms_en), .raw(pwr_src),
        .short_req(pwr_short), .long_req(pwr_long)
    );

    press_classifier #(
        .DEBOUNCE_MS(DEBOUNCE_MS), .SHORT_MIN_MS(SHORT_MIN_MS), .LONG_MS(LONG_MS), .LONG_EN(1'b0)
    ) u_rst (
        .clock(clock), .reset(reset), .tick(bus.int_1ms_en), .raw(rst_src),
        .short_req(rst_short), .long_req(rst_long)
    );

    always_comb begin
        meta_d = {bus.pwr_btn, bus.bmc_power_out, bus.rst_btn, bus.bmc_reset_out, bus.host_reboot, bus.post_complete};
        sync_d = meta_q;
        pwr_src = !(sync_q[5] && sync_q[4]);
        rst_src = !(sync_q[3] && sync_q[2]);
        pc = sync_q[0];
        hr_prev_d = sync_q[1];
        host_fire = host_armed_q && pc && !bus.host_pwr_off && bus.int_1ms_en && host_cnt_q == HOST_LAST;
        host_cnt_d = (!pc || bus.host_pwr_off || !host_armed_q) ? '0 :
                     bus.int_1ms_en ? host_cnt_q + ms_cnt_t'(1) : host_cnt_q;
        host_armed_d = !pc ? 1'b1 : host_fire ? 1'b0 : host_armed_q;
        req = '0;
        req[EV_FORCE_OFF] = pwr_long;
        req[EV_PWR_ON_OFF] = pwr_short;
        req[EV_NORMAL_REBOOT] = rst_short || rst_long;
        req[EV_HOST_POWER_OFF] = host_fire;
        req[EV_HOST_REBOOT] = sync_q[1] && !hr_prev_q;
        hold = holdoff_q != '0;
        strobe_d = hold ? '0 : pick_first(req);
        holdoff_d = (|strobe_d) ? HOLDOFF : (hold && bus.int_1ms_en) ? holdoff_q - ms_cnt_t'(1) : holdoff_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= SYNC_INIT;
            sync_q <= SYNC_INIT;
            hr_prev_q <= 1'b0;
            host_cnt_q <= '0;
            host_armed_q <= 1'b1;
            holdoff_q <= '0;
            strobe_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hr_prev_q <= hr_prev_d;
            host_cnt_q <= host_cnt_d;
            host_armed_q <= host_armed_d;
            holdoff_q <= holdoff_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.is_pwr_force_off  = !strobe_q[EV_FORCE_OFF];
    assign bus.is_pwr_on_off     = !strobe_q[EV_PWR_ON_OFF];
    assign bus.is_normal_reboot  = !strobe_q[EV_NORMAL_REBOOT];
    assign bus.is_host_power_off = !strobe_q[EV_HOST_POWER_OFF];
    assign bus.is_host_reboot    = !strobe_q[EV_HOST_REBOOT];
endmodule

// File: tb/tb_pwr_event_decoder.sv
// tb_pwr_event_decoder: directed and random event scenarios checked against a millisecond-level event model
module tb_pwr_event_decoder;
    import pwr_event_decoder_pkg::*;

    typedef struct {int kind; int ms;} ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    pwr_event_decoder_if bus();
    pwr_event_decoder dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int ms_now = 0;
    int last_ms = 0;
    bit have_last = 1'b0;
    bit prev_low = 1'b0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    logic [4:0] strobes;

    assign strobes = {~bus.is_host_reboot, ~bus.is_host_power_off, ~bus.is_normal_reboot,
                      ~bus.is_pwr_on_off, ~bus.is_pwr_force_off};

    task automatic check(string tag, int got, int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // 1 ms tick every 4 clocks
    initial begin
        bus.int_1ms_en = 1'b0;
        forever begin
            repeat (3) @(negedge clock);
            bus.int_1ms_en = 1'b1;
            @(negedge clock);
            bus.int_1ms_en = 1'b0;
        end
    end

    always @(posedge clock) if (bus.int_1ms_en) ms_now <= ms_now + 1;

    always @(negedge clock) begin
        if (strobes != 5'd0) begin
            check("onehot", $countones(strobes), 1);
            check("width", int'(prev_low), 0);
            for (int k = 0; k < NUM_EV; k++)
                if (strobes[k]) obs_q.push_back('{k, ms_now});
        end
        prev_low = (strobes != 5'd0);
    end

    // Reference model: an event survives unless it lands inside the holdoff window of the last kept one
    function automatic void expect_ev(int kind, int ms);
        if (have_last && ms - last_ms <= HOLDOFF_MS_DEF) return;
        exp_q.push_back('{kind, ms});
        have_last = 1'b1;
        last_ms = ms;
    endfunction

    task automatic wait_ms(int n);
        repeat (n) begin
            @(posedge clock);
            while (!bus.int_1ms_en) @(posedge clock);
        end
        @(negedge clock);
    endtask

    task automatic drive(int src, logic v);
        case (src)
            0: bus.pwr_btn = v;
            1: bus.bmc_power_out = v;
            2: bus.rst_btn = v;
            default: bus.bmc_reset_out = v;
        endcase
    endtask

    task automatic button(int src, int d);
        int p;
        p = ms_now;
        if (src < 2) begin
            if (d > LONG_MS_DEF) expect_ev(EV_FORCE_OFF, p + DEBOUNCE_MS_DEF + LONG_MS_DEF);
            else if (d > SHORT_MIN_MS_DEF) expect_ev(EV_PWR_ON_OFF, p + d + DEBOUNCE_MS_DEF);
        end else if (d > SHORT_MIN_MS_DEF) expect_ev(EV_NORMAL_REBOOT, p + d + DEBOUNCE_MS_DEF);
        drive(src, 1'b0);
        wait_ms(d);
        drive(src, 1'b1);
    endtask

    task automatic host_off(int h, bit hpo);
        if (!hpo && h >= HOST_MIN_MS_DEF) expect_ev(EV_HOST_POWER_OFF, ms_now + HOST_MIN_MS_DEF);
        bus.host_pwr_off = hpo;
        bus.post_complete = 1'b1;
        wait_ms(h);
        bus.post_complete = 1'b0;
        wait_ms(2);
        bus.host_pwr_off = 1'b0;
    endtask

    task automatic host_rb();
        expect_ev(EV_HOST_REBOOT, ms_now);
        bus.host_reboot = 1'b1;
        wait_ms(10);
        bus.host_reboot = 1'b0;
    endtask

    task automatic settle(string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            check({tag, "_ms"}, (obs_q[i].ms - exp_q[i].ms <= 2 && exp_q[i].ms - obs_q[i].ms <= 2) ?
                  exp_q[i].ms : obs_q[i].ms, exp_q[i].ms);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int r, op, d, src, off;
        bit hpo;
        bus.pwr_btn = 1'b1;
        bus.rst_btn = 1'b1;
        bus.bmc_power_out = 1'b1;
        bus.bmc_reset_out = 1'b1;
        bus.host_reboot = 1'b0;
        bus.post_complete = 1'b0;
        bus.host_pwr_off = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_strobes", int'(strobes), 0);
        reset = 1'b0;
        wait_ms(50);

        button(0, 1000);
        wait_ms(300);
        settle("short_press");

        button(1, 5000);
        wait_ms(300);
        settle("long_press");

        for (int i = 0; i < 3; i++) begin
            drive(2, logic'(i % 2));
            wait_ms(5);
        end
        button(2, 30);
        wait_ms(100);
        button(2, 200);
        wait_ms(300);
        settle("reset_button");

        host_off(150, 1'b0);
        wait_ms(300);
        host_off(150, 1'b1);
        wait_ms(300);
        settle("host_off");

        // Host reboot edge lands on the cycle the power release is accepted
        drive(0, 1'b0);
        wait_ms(300);
        drive(0, 1'b1);
        r = ms_now;
        expect_ev(EV_PWR_ON_OFF, r + DEBOUNCE_MS_DEF);
        expect_ev(EV_HOST_REBOOT, r + DEBOUNCE_MS_DEF);
        wait_ms(DEBOUNCE_MS_DEF - 1);
        @(negedge clock);
        bus.host_reboot = 1'b1;
        wait_ms(4);
        bus.host_reboot = 1'b0;
        button(0, 80);
        wait_ms(150);
        host_rb();
        wait_ms(50);
        settle("arb_holdoff");

        drive(0, 1'b0);
        wait_ms(500);
        reset = 1'b1;
        have_last = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_reset_strobes", int'(strobes), 0);
        reset = 1'b0;
        wait_ms(300);
        drive(0, 1'b1);
        wait_ms(300);
        settle("reset_mid_press");

        for (int n = 0; n < 20; n++) begin
            op = $urandom_range(0, 2);
            src = 0;
            d = 0;
            hpo = 1'b0;
            off = 0;
            if (op == 0) begin
                src = $urandom_range(0, 3);
                d = ($urandom_range(0, 1) == 1) ? $urandom_range(60, 300) : $urandom_range(5, 40);
                off = d + DEBOUNCE_MS_DEF;
            end else if (op == 1) begin
                d = $urandom_range(20, 200);
                if (d inside {[95:105]}) d += 15;
                hpo = ($urandom_range(0, 3) == 0);
                off = HOST_MIN_MS_DEF;
            end
            if (have_last && (ms_now + off - last_ms) inside {[HOLDOFF_MS_DEF-10:HOLDOFF_MS_DEF+10]})
                wait_ms(25);
            case (op)
                0: button(src, d);
                1: host_off(d, hpo);
                default: host_rb();
            endcase
            wait_ms($urandom_range(25, 250));
        end
        wait_ms(300);
        settle("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
